// File: rtl/i2c_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2c_rx
// Brief    : Byte-oriented I2C target receiver for write transfers. It presents
//            each received data byte with a one-cycle wr_en strobe.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_rx #(
    parameter int         BYTES      = 2,
    parameter logic [6:0] ADDR       = 7'h20,
    localparam int        INDEX_BITS = $clog2(BYTES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [7:0]            data_out,
    output logic [INDEX_BITS-1:0] index_out,
    output logic                  wr_en,
    output logic                  frame_done,
    output logic                  busy
);

    // The byte counter needs one extra code so that it can mark "frame full".
    localparam int                 c_cnt_w = $clog2(BYTES + 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(BYTES);

    typedef enum logic [2:0] {
        c_idle   = 3'd0,
        c_addr   = 3'd1,
        c_ack_a  = 3'd2,
        c_data   = 3'd3,
        c_ack_d  = 3'd4,
        c_ignore = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_scl_s1, r_scl_s2, r_scl_prev;
    logic               r_sda_s1, r_sda_s2, r_sda_prev;
    logic [6:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [c_cnt_w-1:0] r_count;
    logic               r_acked;

    logic       w_scl_rise, w_scl_fall, w_scl_high;
    logic       w_start, w_stop, w_last_bit;
    logic [7:0] w_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_s1   <= scl;
            r_scl_s2   <= r_scl_s1;
            r_scl_prev <= r_scl_s2;
            r_sda_s1   <= sda_in;
            r_sda_s2   <= r_sda_s1;
            r_sda_prev <= r_sda_s2;
        end
    end

    // START/STOP require SCL steady high, so a simultaneous SCL edge wins.
    assign w_scl_rise = r_scl_s2 & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_s2 & r_scl_prev;
    assign w_scl_high = r_scl_s2 & r_scl_prev;
    assign w_start    = w_scl_high & r_sda_prev & ~r_sda_s2;
    assign w_stop     = w_scl_high & ~r_sda_prev & r_sda_s2;
    assign w_byte     = {r_shift, r_sda_s2};
    assign w_last_bit = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_idle;
            r_shift    <= 7'd0;
            r_bit_cnt  <= 3'd0;
            r_count    <= '0;
            r_acked    <= 1'b0;
            sda_oe     <= 1'b0;
            data_out   <= 8'd0;
            index_out  <= '0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (w_stop) begin
                r_state    <= c_idle;
                sda_oe     <= 1'b0;
                busy       <= 1'b0;
                frame_done <= r_acked;
                r_acked    <= 1'b0;
            end else if (w_start) begin
                r_state   <= c_addr;
                r_bit_cnt <= 3'd0;
                r_count   <= '0;
                r_acked   <= 1'b0;
                sda_oe    <= 1'b0;
            end else begin
                case (r_state)
                    c_addr: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_state <= (w_byte == {ADDR, 1'b0}) ? c_ack_a : c_ignore;
                            end
                        end
                    end
                    c_ack_a: begin
                        if (w_scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                r_count   <= '0;
                                r_bit_cnt <= 3'd0;
                                busy      <= 1'b1;
                                r_state   <= c_data;
                            end
                        end
                    end
                    c_data: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                if (r_count == c_full) begin
                                    r_state <= c_ignore;
                                end else begin
                                    data_out  <= w_byte;
                                    index_out <= r_count[INDEX_BITS-1:0];
                                    wr_en     <= 1'b1;
                                    r_state   <= c_ack_d;
                                end
                            end
                        end
                    end
                    c_ack_d: begin
                        if (w_scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe  <= 1'b1;
                                r_acked <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_count <= r_count + 1'b1;
                                r_state <= c_data;
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_rx
// Brief    : Self-checking bench for i2c_rx with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_rx;

    localparam int         BYTES = 2;
    localparam logic [6:0] ADDR  = 7'h20;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       scl = 1'b1;
    logic                       sda_m = 1'b1;
    logic                       sda_in;
    logic                       sda_oe;
    logic [7:0]                 data_out;
    logic [$clog2(BYTES)-1:0]   index_out;
    logic                       wr_en;
    logic                       frame_done;
    logic                       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] wq_d[$];
    int         wq_i[$];
    int         fd_total = 0;
    logic [7:0] fbytes[0:7];

    // Wired-AND bus: master drive combined with the target's ACK pull-down.
    assign sda_in = sda_m & ~sda_oe;

    i2c_rx #(.BYTES(BYTES), .ADDR(ADDR)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe),
        .data_out   (data_out),
        .index_out  (index_out),
        .wr_en      (wr_en),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wq_d.push_back(data_out);
            wq_i.push_back(int'(index_out));
        end
        if (frame_done) fd_total++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        wait_clk(4); sda_m = 1'b1;
        wait_clk(4); scl = 1'b1;
        wait_clk(8); sda_m = 1'b0;
        wait_clk(8); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(4); sda_m = 1'b0;
        wait_clk(4); scl = 1'b1;
        wait_clk(8); sda_m = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_bit(input logic b, output logic oe_hi, output logic busy_hi);
        wait_clk(4); sda_m = b;
        wait_clk(4); scl = 1'b1;
        wait_clk(4); oe_hi = sda_oe; busy_hi = busy;
        wait_clk(4); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack, output logic busy_ack,
                             output int stray);
        logic oe, bz;
        stray = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], oe, bz);
            if (oe) stray++;
        end
        send_bit(1'b1, ack, busy_ack);
    endtask

    // Drives one write frame and checks it against what the protocol rules predict.
    task automatic run_frame(input logic [7:0] abyte, input int n);
        logic ack, bz;
        int   stray, q0, f0, exp_w, exp_fd;
        logic addr_ok, exp_ack;
        q0 = wq_d.size();
        f0 = fd_total;
        addr_ok = (abyte == {ADDR, 1'b0});
        exp_w   = addr_ok ? ((n < BYTES) ? n : BYTES) : 0;
        exp_fd  = (addr_ok && n >= 1) ? 1 : 0;

        bus_start();
        send_byte(abyte, ack, bz, stray);
        checks++;
        if (ack !== addr_ok) begin
            errors++;
            $display("FAIL addr_ack abyte=%h: got %b want %b", abyte, ack, addr_ok);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL addr_stray_oe abyte=%h: got %0d want 0", abyte, stray);
        end
        for (int i = 0; i < n; i++) begin
            send_byte(fbytes[i], ack, bz, stray);
            exp_ack = addr_ok && (i < BYTES);
            checks++;
            if (ack !== exp_ack) begin
                errors++;
                $display("FAIL data_ack[%0d]: got %b want %b", i, ack, exp_ack);
            end
            checks++;
            if (bz !== exp_ack) begin
                errors++;
                $display("FAIL busy_at_ack[%0d]: got %b want %b", i, bz, exp_ack);
            end
            checks++;
            if (stray !== 0) begin
                errors++;
                $display("FAIL data_stray_oe[%0d]: got %0d want 0", i, stray);
            end
        end
        bus_stop();
        wait_clk(6);

        checks++;
        if (wq_d.size() - q0 !== exp_w) begin
            errors++;
            $display("FAIL wr_count: got %0d want %0d", wq_d.size() - q0, exp_w);
        end
        for (int i = 0; i < exp_w; i++) begin
            if (q0 + i < wq_d.size()) begin
                checks++;
                if (wq_d[q0+i] !== fbytes[i] || wq_i[q0+i] !== i) begin
                    errors++;
                    $display("FAIL wr_entry[%0d]: got (%h,%0d) want (%h,%0d)",
                             i, wq_d[q0+i], wq_i[q0+i], fbytes[i], i);
                end
            end
        end
        checks++;
        if (fd_total - f0 !== exp_fd) begin
            errors++;
            $display("FAIL frame_done_count: got %0d want %0d", fd_total - f0, exp_fd);
        end
        checks++;
        if (busy !== 1'b0 || sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_stop: got busy=%b oe=%b want 0 0", busy, sda_oe);
        end
    endtask

    task automatic test_reset();
        wait_clk(4);
        reset = 1'b0;
        wait_clk(10);
        checks++;
        if ({sda_oe, wr_en, frame_done, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got oe/wr/fd/busy=%b want 0000",
                     {sda_oe, wr_en, frame_done, busy});
        end
        checks++;
        if (data_out !== 8'h00 || index_out !== '0) begin
            errors++;
            $display("FAIL reset_data: got (%h,%0d) want (00,0)", data_out, index_out);
        end
        checks++;
        if (wq_d.size() !== 0 || fd_total !== 0) begin
            errors++;
            $display("FAIL reset_strobes: got wr=%0d fd=%0d want 0 0", wq_d.size(), fd_total);
        end
    endtask

    task automatic test_basic();
        fbytes[0] = 8'hA5; fbytes[1] = 8'h3C;
        run_frame(8'h40, 2);
    endtask

    task automatic test_wrong_addr();
        fbytes[0] = 8'h5A; fbytes[1] = 8'hC3;
        run_frame(8'h42, 2);
        run_frame(8'h41, 2);
    endtask

    task automatic test_overflow();
        fbytes[0] = 8'h11; fbytes[1] = 8'h22; fbytes[2] = 8'h33;
        run_frame(8'h40, 3);
    endtask

    task automatic test_repeated_start();
        logic ack, bz, oe;
        int   stray;
        bus_start();
        send_byte(8'h40, ack, bz, stray);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL rs_addr_ack: got %b want 1", ack);
        end
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1), oe, bz);
        fbytes[0] = 8'h77;
        run_frame(8'h40, 1);
    endtask

    task automatic test_reset_mid_frame();
        logic ack, bz, oe;
        logic [7:0] b;
        int   stray, q0, f0;
        b = 8'h5A;
        bus_start();
        send_byte(8'h40, ack, bz, stray);
        for (int i = 7; i >= 0; i--) send_bit(b[i], oe, bz);
        wait_clk(6);
        checks++;
        if (sda_oe !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack_oe: got %b want 1", sda_oe);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (sda_oe !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got oe=%b busy=%b data=%h want 0 0 00",
                     sda_oe, busy, data_out);
        end
        wait_clk(2);
        reset = 1'b0;
        q0 = wq_d.size();
        f0 = fd_total;
        send_bit(1'b1, oe, bz);
        send_byte(8'h66, ack, bz, stray);
        checks++;
        if (oe !== 1'b0 || ack !== 1'b0 || stray !== 0) begin
            errors++;
            $display("FAIL post_reset_drive: got oe=%b ack=%b stray=%0d want 0 0 0",
                     oe, ack, stray);
        end
        bus_stop();
        wait_clk(6);
        checks++;
        if (wq_d.size() !== q0 || fd_total !== f0) begin
            errors++;
            $display("FAIL post_reset_strobes: got wr=%0d fd=%0d want 0 0",
                     wq_d.size() - q0, fd_total - f0);
        end
    endtask

    task automatic test_random();
        logic [7:0] abyte;
        int         n;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 4))
                0, 1:    abyte = 8'h40;
                2:       abyte = 8'h42;
                3:       abyte = 8'h41;
                default: abyte = 8'($urandom);
            endcase
            n = $urandom_range(0, 3);
            for (int i = 0; i < 8; i++) fbytes[i] = 8'($urandom);
            run_frame(abyte, n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrong_addr();
        test_overflow();
        test_repeated_start();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
